// File: rtl/move_cmd_gen.sv
// move_cmd_gen: turns raw pushbuttons into debounced, arbitrated valid/ready move requests.
// Define MOVE_REPEAT_EN to auto-repeat a move while its direction button stays held.
module move_cmd_gen #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 20_000_000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       btnU,
    input  logic       btnD,
    input  logic       btnL,
    input  logic       btnR,
    input  logic       btnC,
    input  logic       move_ready,
    output logic       move_valid,
    output logic [1:0] move_dir,
    output logic       check_pulse
);
    localparam int NUM_BTN = 5;
    localparam int BTN_C   = 4;
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

    // Bit index equals the move_dir code, so the held button is deb_q[dir_q].
    logic [NUM_BTN-1:0] raw;
    assign raw = {btnC, btnL, btnD, btnR, btnU};

    logic [NUM_BTN-1:0]           sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NUM_BTN-1:0]           deb_q, deb_d, deb_prev_q, deb_prev_d;
    logic [NUM_BTN-1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [NUM_BTN-1:0]           press;

    state_t     state_q, state_d;
    logic [1:0] dir_q, dir_d;
    logic       dir_evt;
    logic [1:0] evt_dir;

`ifdef MOVE_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_first_q, rpt_first_d;
`else
    logic unused_rpt_params;
    assign unused_rpt_params = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

    always_comb begin
        sync1_d    = raw;
        sync2_d    = sync1_q;
        deb_prev_d = deb_q;
        deb_d      = deb_q;
        db_cnt_d   = db_cnt_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                deb_d[i]    = sync2_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
    end

    assign press = deb_q & ~deb_prev_q;

    // Fixed priority U > R > D > L; losers are simply dropped.
    always_comb begin
        dir_evt = |press[3:0];
        evt_dir = 2'd0;
        if (press[0])      evt_dir = 2'd0;
        else if (press[1]) evt_dir = 2'd1;
        else if (press[2]) evt_dir = 2'd2;
        else if (press[3]) evt_dir = 2'd3;
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
`ifdef MOVE_REPEAT_EN
        rpt_cnt_d   = rpt_cnt_q;
        rpt_first_d = rpt_first_q;
`endif
        case (state_q)
            IDLE: begin
                if (dir_evt) begin
                    dir_d   = evt_dir;
                    state_d = SEND;
`ifdef MOVE_REPEAT_EN
                    rpt_first_d = 1'b1;
`endif
                end
            end
            SEND: begin
                if (move_ready) begin
                    state_d = HOLD;
`ifdef MOVE_REPEAT_EN
                    rpt_cnt_d = '0;
`endif
                end
            end
            HOLD: begin
                // Release wins over a repeat that would fire on the same cycle.
                if (!deb_q[dir_q]) begin
                    state_d = IDLE;
`ifdef MOVE_REPEAT_EN
                    rpt_cnt_d = '0;
`endif
                end else begin
`ifdef MOVE_REPEAT_EN
                    if (rpt_cnt_q == (rpt_first_q ? RPT_FIRST : RPT_NEXT)) begin
                        state_d     = SEND;
                        rpt_cnt_d   = '0;
                        rpt_first_d = 1'b0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            db_cnt_q   <= '0;
            state_q    <= IDLE;
            dir_q      <= 2'd0;
`ifdef MOVE_REPEAT_EN
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b0;
`endif
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            db_cnt_q   <= db_cnt_d;
            state_q    <= state_d;
            dir_q      <= dir_d;
`ifdef MOVE_REPEAT_EN
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_first_q <= rpt_first_d;
`endif
        end
    end

    assign move_valid  = (state_q == SEND);
    assign move_dir    = dir_q;
    assign check_pulse = press[BTN_C];

endmodule
